// File: rtl/if_id_prefetch_queue.sv
// if_id_prefetch_queue
// Small synchronous FIFO between instruction fetch and instruction decode. Buffers
// {pc, instruction} pairs so fetch keeps running while decode is stalled; a taken
// branch (flush) discards every buffered entry.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   flush            branch taken; empties the queue at the next edge
//   in_valid/in_ready, in_pc, in_instruction      push side (fetch)
//   out_valid/out_ready, out_pc, out_instruction  pop side (decode)
//   count            current occupancy, 0..DEPTH
//
// Build option:
//   IFQ_BYPASS_EN    when defined, an entry presented to an empty queue appears on the
//                    outputs combinationally and is consumed without a write if
//                    out_ready is high. Undefined: strict one-cycle fall-through latency.
module if_id_prefetch_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ADDRESS_LEN = 32,
    parameter int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [ADDRESS_LEN-1:0] in_pc,
    input  logic [ADDRESS_LEN-1:0] in_instruction,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [ADDRESS_LEN-1:0] out_pc,
    output logic [ADDRESS_LEN-1:0] out_instruction,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [2*ADDRESS_LEN-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]         count_q;

    logic                     empty;
    logic                     bypass;
    logic                     push;
    logic                     pop;

    assign empty    = (count_q == '0);
    // Depends only on the count register, so out_ready never reaches in_ready.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign count    = count_q;

`ifdef IFQ_BYPASS_EN
    // Reset also suppresses the bypass so outputs read idle while rst is held.
    assign bypass = empty & in_valid & ~flush & ~rst;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        // A bypassed entry that decode takes this cycle is never written.
        push = in_valid & in_ready & ~flush & ~(bypass & out_ready);
        pop  = ~empty & out_ready & ~flush;
    end

    always_comb begin
        out_valid       = ~empty | bypass;
        out_pc          = '0;
        out_instruction = '0;
        if (bypass) begin
            out_pc          = in_pc;
            out_instruction = in_instruction;
        end else if (!empty) begin
            out_pc          = mem_q[rd_ptr_q][2*ADDRESS_LEN-1:ADDRESS_LEN];
            out_instruction = mem_q[rd_ptr_q][ADDRESS_LEN-1:0];
        end
    end

    // Storage is not cleared by reset or flush; count alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_pc, in_instruction};
        end
    end

    // Pointers are PTR_W bits wide, so DEPTH-1 + 1 wraps to 0 naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_id_prefetch_queue.sv
module tb_if_id_prefetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AL    = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [AL-1:0] in_pc;
    logic [AL-1:0] in_instruction;
    logic          in_ready;
    logic          out_valid;
    logic [AL-1:0] out_pc;
    logic [AL-1:0] out_instruction;
    logic          out_ready;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_prefetch_queue #(
        .DEPTH       (DEPTH),
        .ADDRESS_LEN (AL),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_ready       (out_ready),
        .count           (count)
    );

    // Inputs for one cycle and the outputs expected just after that cycle's edge,
    // with the same inputs still applied.
    typedef struct {
        logic          rst;
        logic          flush;
        logic          iv;
        logic [AL-1:0] pc;
        logic          ordy;
        int            e_cnt;
        logic          e_ov;
        logic [AL-1:0] e_pc;
        logic          e_ir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic iv, input logic [AL-1:0] pc,
                       input logic ordy, input int e_cnt, input logic e_ov,
                       input logic [AL-1:0] e_pc, input logic e_ir);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_pc = e_pc; v.e_ir = e_ir;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [AL-1:0] act,
                         input logic [AL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [AL-1:0] pc,
                         input logic ordy);
        rst = r; flush = f; in_valid = iv; in_pc = pc; in_instruction = ~pc; out_ready = ordy;
    endtask

    task automatic check_outputs(input int idx, input int e_cnt, input logic e_ov,
                                 input logic [AL-1:0] e_pc, input logic e_ir);
        logic [AL-1:0] e_instr;
        e_instr = e_ov ? ~e_pc : '0;
        check("count", idx, AL'(count), AL'(e_cnt));
        check("out_valid", idx, AL'(out_valid), AL'(e_ov));
        check("out_pc", idx, out_pc, e_pc);
        check("out_instruction", idx, out_instruction, e_instr);
        check("in_ready", idx, AL'(in_ready), AL'(e_ir));
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Reset held two cycles with fetch presenting an entry.
        add(1, 0, 1, 32'h99, 0,   0, 0, 32'h0, 1);
        add(1, 0, 1, 32'h99, 0,   0, 0, 32'h0, 1);
        // Fill with decode stalled; the fifth push is held.
        add(0, 0, 1, 32'h4,  0,   1, 1, 32'h4, 1);
        add(0, 0, 1, 32'h8,  0,   2, 1, 32'h4, 1);
        add(0, 0, 1, 32'hC,  0,   3, 1, 32'h4, 1);
        add(0, 0, 1, 32'h10, 0,   4, 1, 32'h4, 0);
        add(0, 0, 1, 32'h14, 0,   4, 1, 32'h4, 0);
        // Full with pop: push rejected, then accepted next cycle.
        add(0, 0, 1, 32'h14, 1,   3, 1, 32'h8, 1);
        add(0, 0, 1, 32'h14, 1,   3, 1, 32'hC, 1);
        add(0, 0, 0, 32'h0,  1,   2, 1, 32'h10, 1);
        add(0, 0, 0, 32'h0,  1,   1, 1, 32'h14, 1);
        add(0, 0, 0, 32'h0,  1,   0, 0, 32'h0, 1);
        // Wrap-around: prime to count 2, then ten push+pop cycles.
        add(0, 0, 1, 32'h1F8, 0,  1, 1, 32'h1F8, 1);
        add(0, 0, 1, 32'h1FC, 0,  2, 1, 32'h1F8, 1);
        for (int k = 0; k < 10; k++) begin
            add(0, 0, 1, 32'h200 + 32'(4 * k), 1,  2, 1, 32'h1FC + 32'(4 * k), 1);
        end
        add(0, 0, 1, 32'h228, 0,  3, 1, 32'h220, 1);
        // Flush with a push and pop pending: 0x40 is dropped.
        add(0, 1, 1, 32'h40,  1,  0, 0, 32'h0, 1);
        add(0, 0, 1, 32'h100, 0,  1, 1, 32'h100, 1);
        add(0, 0, 1, 32'h104, 0,  2, 1, 32'h100, 1);
        add(0, 0, 1, 32'h108, 0,  3, 1, 32'h100, 1);
        add(0, 0, 1, 32'h10C, 0,  4, 1, 32'h100, 0);
        add(0, 0, 1, 32'h110, 1,  3, 1, 32'h104, 1);
        add(0, 0, 1, 32'h110, 1,  3, 1, 32'h108, 1);
        add(0, 0, 0, 32'h0,   1,  2, 1, 32'h10C, 1);
        add(0, 0, 0, 32'h0,   1,  1, 1, 32'h110, 1);
        add(0, 0, 0, 32'h0,   1,  0, 0, 32'h0, 1);
        // Mid-operation reset, asserted together with flush.
        add(0, 0, 1, 32'h500, 0,  1, 1, 32'h500, 1);
        add(0, 0, 1, 32'h504, 0,  2, 1, 32'h500, 1);
        add(1, 1, 1, 32'h508, 1,  0, 0, 32'h0, 1);
        add(0, 0, 0, 32'h0,   0,  0, 0, 32'h0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].e_cnt, vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_ir);
        end

        // Full queue: in_ready stays low while out_ready toggles before the edge.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h600, 1'b0);
        for (int k = 0; k < 4; k++) begin
            in_pc = 32'h600 + 32'(4 * k);
            in_instruction = ~in_pc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("full in_ready ordy=0", 100, AL'(in_ready), AL'(0));
        out_ready = 1'b1;
        #1;
        check("full in_ready ordy=1", 101, AL'(in_ready), AL'(0));
        check("full count", 102, AL'(count), AL'(4));
        // Drain (bounded) before the empty-queue latency test.
        for (int k = 0; k < 8 && count != 0; k++) @(negedge clk);
        check("drained count", 103, AL'(count), AL'(0));

        // Empty queue, entry presented with decode ready.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h20, 1'b1);
        #1;
`ifdef IFQ_BYPASS_EN
        check("bypass out_valid", 110, AL'(out_valid), AL'(1));
        check("bypass out_pc", 111, out_pc, 32'h20);
        check("bypass out_instruction", 112, out_instruction, ~32'h20);
`else
        check("no-bypass out_valid", 110, AL'(out_valid), AL'(0));
        check("no-bypass out_pc", 111, out_pc, 32'h0);
`endif
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
`ifdef IFQ_BYPASS_EN
        check("bypass count", 113, AL'(count), AL'(0));
        check("bypass later out_valid", 114, AL'(out_valid), AL'(0));
`else
        check("latency count", 113, AL'(count), AL'(1));
        check("latency out_valid", 114, AL'(out_valid), AL'(1));
        check("latency out_pc", 115, out_pc, 32'h20);
        check("latency out_instruction", 116, out_instruction, ~32'h20);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("final count", 117, AL'(count), AL'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1);
    end

endmodule
